fp_result_sink: RTL
===================

Name: fp_result_sink

Overview:
- Receiving end of the AXI4-Stream result channel of the double-precision FP operator IP cores (add/mul/div) in the Kalman datapath.
- Accepts m_axis_result beats with real tready backpressure and buffers them in a small FIFO.
- Presents results to the consumer on a valid/ready interface.
- Issues credits to the operand-side wrapper, so the number of requests in flight plus buffered results never exceeds FIFO capacity.

Parameters:
- DW, 64, result data width (IEEE-754 double).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), width of the in-flight and occupancy counters (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_result_tvalid  input  1  IP result beat valid.
- s_axis_result_tready  output  1  sink can accept a beat.
- s_axis_result_tdata  input  DW  IP result data.
- issue  input  1  single-cycle pulse; operand wrapper handed one request to the IP.
- credit_ok  output  1  one more request may be issued.
- m_valid  output  1  result available to consumer.
- m_ready  input  1  consumer accepts result.
- m_data  output  DW  head-of-FIFO result.
- inflight  output  CW  requests issued but not yet returned.
- err_clr  input  1  clears sticky error bits.
- err  output  2  sticky errors: [0] credit overrun, [1] unsolicited return.

Behaviour:
- Reset: asynchronous on rst_n low. Clears the FIFO, pointers, occupancy and inflight. Reset values: s_axis_result_tready=1, credit_ok=1, m_valid=0, m_data=0, inflight=0, err=0.
- Reset mid-operation drops all buffered and in-flight results; the result of any late IP beat after reset counts as an unsolicited return.
- Push: push = s_axis_result_tvalid && s_axis_result_tready; the beat is written at the tail. s_axis_result_tready = (occupancy != DEPTH), registered-state-derived and combinational from the occupancy counter only.
- Pop: pop = m_valid && m_ready; advances the head.
  - m_valid = (occupancy != 0).
  - m_data is read from FIFO RAM at the head pointer. It is stable while m_valid && !m_ready.
- Latency: a beat pushed at edge N is visible on m_valid/m_data after edge N (first-word, one cycle, no fall-through in the same cycle as push).
- Push and pop in the same cycle: occupancy unchanged. When full, tready=0, so push cannot coincide with a full FIFO even if pop is asserted.
- Pointers: log2(DEPTH) bits, wrap naturally modulo DEPTH.
- inflight:
  - +1 on issue, -1 on push.
  - Both in the same cycle: unchanged.
- credit_ok = (inflight + occupancy) < DEPTH, computed from registered counters, no dependence on same-cycle issue/push.
- Error err[0] (credit overrun): issue asserted while credit_ok=0. inflight still increments, saturating at DEPTH.
- Error err[1] (unsolicited return): push while inflight=0. inflight stays 0 and data is still stored.
- err bits are sticky until err_clr. If err_clr and a new error event occur in the same cycle, the event wins (bit set).
- No state machine beyond the counters. Behaviour is fully defined by occupancy, inflight and pointers.
- Ordering is strict FIFO; results leave in the order the IP produced them.

Optional Feature:
- Macro FP_RESULT_SINK_NAN_CHECK_EN.
- When defined:
  - Adds output m_nan (1): asserted with m_valid when m_data exponent bits [62:52] are all ones and mantissa [51:0] is nonzero.
  - Adds output nan_seen (1): sticky, set on any push of a NaN, cleared by err_clr.
  - NaN flag is stored per entry at push (one extra FIFO bit).
- When undefined: ports absent, no extra storage, behaviour otherwise identical.

Test Plan:
- Reset, then idle → tready=1, credit_ok=1, m_valid=0, inflight=0, err=0.
- issue x1. IP returns 0x3FF0000000000000 two cycles later, m_ready=1 → inflight 1→0. m_valid high for one cycle with m_data=0x3FF0000000000000, one cycle after push.
- DEPTH=4, m_ready=0, 4 issues and 4 returns (1.0, 2.0, 3.0, 4.0) → after 4th push tready=0, credit_ok=0. Raise m_ready → data pops in order 1.0, 2.0, 3.0, 4.0, and tready returns to 1 after the first pop.
- Full FIFO with m_ready=1 and tvalid=1 in the same cycle → no push that cycle; occupancy 4→3; the beat is accepted next cycle; no data loss.
- issue while credit_ok=0 → err[0]=1 and held. Push with inflight=0 → err[1]=1. err_clr pulse → err=0. err_clr coincident with a new overrun → err[0] stays 1.
- With FP_RESULT_SINK_NAN_CHECK_EN, return 0x7FF8000000000000 → m_nan=1 with that entry and nan_seen=1. Return 0x7FF0000000000000 (inf) → m_nan=0.

Source files
------------

// File: rtl/fp_result_sink.sv
// Receiving end of the FP operator result stream: buffers result beats in a small
// FIFO, hands them to the consumer in order, and issues credits to the operand side.
// Optional NaN tagging is enabled by defining FP_RESULT_SINK_NAN_CHECK_EN.
module fp_result_sink #(
  parameter  int DW    = 64,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_axis_result_tvalid,
  output logic          s_axis_result_tready,
  input  logic [DW-1:0] s_axis_result_tdata,
  input  logic          issue,
  output logic          credit_ok,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] inflight,
  input  logic          err_clr,
`ifdef FP_RESULT_SINK_NAN_CHECK_EN
  output logic          m_nan,
  output logic          nan_seen,
`endif
  output logic [1:0]    err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum int unsigned {
    ERR_OVERRUN     = 0,
    ERR_UNSOLICITED = 1
  } err_bit_e;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [1:0]    err_q, err_d;
  logic          push, pop;
  logic          inflight_inc, inflight_dec;
  logic [CW:0]   credit_sum;

  // Handshake status comes only from registered counters, so neither ready nor
  // credit can combinationally depend on the same-cycle valid/issue inputs.
  assign s_axis_result_tready = (count_q != FULL_CNT);
  assign m_valid              = (count_q != '0);
  assign push                 = s_axis_result_tvalid && s_axis_result_tready;
  assign pop                  = m_valid && m_ready;
  assign credit_sum           = {1'b0, inflight_q} + {1'b0, count_q};
  assign credit_ok            = (credit_sum < (CW + 1)'(DEPTH));
  assign inflight             = inflight_q;
  assign err                  = err_q;

  // An empty FIFO presents zero rather than stale RAM contents.
  assign m_data = m_valid ? mem[rd_ptr_q] : '0;

  // A return with nothing outstanding is unsolicited and leaves inflight at 0;
  // an issue beyond the credit limit saturates at DEPTH.
  assign inflight_inc = issue && (inflight_q != FULL_CNT);
  assign inflight_dec = push && (inflight_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    err_d      = err_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    if (issue && !push && inflight_inc)      inflight_d = inflight_q + 1'b1;
    else if (!issue && inflight_dec)         inflight_d = inflight_q - 1'b1;
    else if (issue && push && !inflight_dec) inflight_d = inflight_q + (inflight_inc ? 1'b1 : 1'b0);

    // Clear first so a coincident new event wins.
    if (err_clr) err_d = '0;
    if (issue && !credit_ok)          err_d[ERR_OVERRUN]     = 1'b1;
    if (push && (inflight_q == '0))   err_d[ERR_UNSOLICITED] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the combinational block above uses blocking with defaults first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, and m_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_axis_result_tdata;
  end

`ifdef FP_RESULT_SINK_NAN_CHECK_EN
  logic nan_mem [DEPTH];
  logic in_is_nan;
  logic nan_seen_q;

  assign in_is_nan = (&s_axis_result_tdata[62:52]) && (|s_axis_result_tdata[51:0]);
  assign m_nan     = m_valid && nan_mem[rd_ptr_q];
  assign nan_seen  = nan_seen_q;

  always_ff @(posedge clk) begin
    if (push) nan_mem[wr_ptr_q] <= in_is_nan;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_seen_q <= 1'b0;
    end else if (push && in_is_nan) begin
      nan_seen_q <= 1'b1;
    end else if (err_clr) begin
      nan_seen_q <= 1'b0;
    end
  end
`endif

endmodule
